// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_if push/pop handshake and FIFO storage blocks.
package fifo_pkg;

   typedef enum logic {NO_PUSH = 1'b0, PUSH = 1'b1} push_e_t;
   typedef enum logic {NO_POP  = 1'b0, POP  = 1'b1} pop_e_t;

   localparam int DATA_W_DEF = 8;
   typedef logic [DATA_W_DEF-1:0] data_t;

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Modulo-DEPTH pointer: advances on inc and wraps DEPTH-1 -> 0, so any DEPTH works.
module fifo_ptr_ctr #(
   parameter  int DEPTH = 16,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (inc)
         ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and registered read data.
// Optional sticky overflow/underflow ports are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_param import fifo_pkg::*; #(
   parameter  int DATA_W    = DATA_W_DEF,
   parameter  int DEPTH     = 16,
   parameter  int AF_THRESH = DEPTH - 2,
   parameter  int AE_THRESH = 1,
   localparam int CNT_W     = cnt_w(DEPTH),
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  push_e_t           push,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   output logic              almost_full,
   input  pop_e_t            pop,
   output logic [DATA_W-1:0] data_out,
   output logic              empty,
   output logic              almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
   output logic              overflow,
   output logic              underflow,
`endif
   output logic [CNT_W-1:0]  count
);

   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "fifo_sync_param: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $fatal(1, "fifo_sync_param: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $fatal(1, "fifo_sync_param: AE_THRESH must be in 0..DEPTH-1");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              push_acc, pop_acc;

   // A pop frees a slot in the same edge, so a full FIFO still takes a push alongside it.
   assign pop_acc  = (pop == POP) && !empty;
   assign push_acc = (push == PUSH) && (!full || pop_acc);

   fifo_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (push_acc),
      .ptr   (wr_ptr)
   );

   fifo_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pop_acc),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (rst_n && push_acc)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data_out <= '0;
      else if (pop_acc)
         data_out <= mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (push_acc && !pop_acc)
         count <= count + 1'b1;
      else if (pop_acc && !push_acc)
         count <= count - 1'b1;
   end

   assign full         = (count == CNT_W'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_W'(AF_THRESH));
   assign almost_empty = (count <= CNT_W'(AE_THRESH));

`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if ((push == PUSH) && full && !pop_acc)
            overflow <= 1'b1;
         if ((pop == POP) && empty)
            underflow <= 1'b1;
      end
   end
`endif

endmodule
